// File: rtl/counter_updn_n_if.sv
// Control and status bundle for counter_updn_n: request inputs toward the counter,
// registered count and flags back out.
interface counter_updn_n_if #(
  parameter int WIDTH = 3
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             inc;
  logic             dec;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tc_up;
  logic             tc_dn;
  logic             ovf;

  modport master (
    output clr, load, d_in, inc, dec, mode,
    input  count, tc_up, tc_dn, ovf
  );

  modport slave (
    input  clr, load, d_in, inc, dec, mode,
    output count, tc_up, tc_dn, ovf
  );
endinterface

// File: rtl/counter_updn_n.sv
// Up/down counter over 0..MAX_VAL with load, clear, per-cycle wrap/saturate mode,
// terminal-count pulses and a sticky overflow flag.
module counter_updn_n #(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = 7,
  parameter int RESET_VAL = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  counter_updn_n_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH-1:0] count_q;
  logic             tc_up_q;
  logic             tc_dn_q;
  logic             ovf_q;
  logic             load_ok;
  logic             at_max;
  logic             at_zero;

  // Widened compare so a full-range MAX_VAL does not fold into a constant.
  assign load_ok = ({1'b0, bus.d_in} <= MAX_EXT);
  assign at_max  = (count_q == MAX_CNT);
  assign at_zero = (count_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_CNT;
      tc_up_q <= 1'b0;
      tc_dn_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tc_up_q <= 1'b0;
      tc_dn_q <= 1'b0;
      if (bus.clr) begin
        count_q <= RST_CNT;
        ovf_q   <= 1'b0;
      end else if (bus.load) begin
        if (load_ok) begin
          count_q <= bus.d_in;
        end else begin
          count_q <= MAX_CNT;
          ovf_q   <= 1'b1;
        end
      end else if (bus.inc && !bus.dec) begin
        if (!at_max) begin
          count_q <= count_q + 1'b1;
        end else begin
          tc_up_q <= 1'b1;
          if (bus.mode) ovf_q <= 1'b1;
          else          count_q <= '0;
        end
      end else if (bus.dec && !bus.inc) begin
        if (!at_zero) begin
          count_q <= count_q - 1'b1;
        end else begin
          tc_dn_q <= 1'b1;
          if (bus.mode) ovf_q <= 1'b1;
          else          count_q <= MAX_CNT;
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc_up = tc_up_q;
  assign bus.tc_dn = tc_dn_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_counter_updn_n.sv
// Directed bench for counter_updn_n: vector table on the default instance plus
// hand sequences for saturation, clamped load, long wrap and async reset.
module tb_counter_updn_n;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  counter_updn_n_if #(.WIDTH(3)) ia ();
  counter_updn_n_if #(.WIDTH(3)) ib ();
  counter_updn_n_if #(.WIDTH(8)) ic ();

  counter_updn_n #(.WIDTH(3), .MAX_VAL(7),   .RESET_VAL(0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
  counter_updn_n #(.WIDTH(3), .MAX_VAL(5),   .RESET_VAL(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib.slave));
  counter_updn_n #(.WIDTH(8), .MAX_VAL(200), .RESET_VAL(0)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ic.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       load;
    logic [2:0] d_in;
    logic       inc;
    logic       dec;
    logic       mode;
    int         e_count;
    int         e_up;
    int         e_dn;
    int         e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic c, input logic l, input logic [2:0] d,
                              input logic i, input logic dn, input logic m,
                              input int ec, input int eu, input int ed, input int eo);
    vec_t v;
    v.name = nm; v.clr = c; v.load = l; v.d_in = d; v.inc = i; v.dec = dn; v.mode = m;
    v.e_count = ec; v.e_up = eu; v.e_dn = ed; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input int ec, input int eu, input int ed, input int eo);
    check({nm, ".count"}, int'(ia.count), ec);
    check({nm, ".tc_up"}, int'(ia.tc_up), eu);
    check({nm, ".tc_dn"}, int'(ia.tc_dn), ed);
    check({nm, ".ovf"},   int'(ia.ovf),   eo);
  endtask

  task automatic chk_b(input string nm, input int ec, input int eu, input int ed, input int eo);
    check({nm, ".count"}, int'(ib.count), ec);
    check({nm, ".tc_up"}, int'(ib.tc_up), eu);
    check({nm, ".tc_dn"}, int'(ib.tc_dn), ed);
    check({nm, ".ovf"},   int'(ib.ovf),   eo);
  endtask

  task automatic drive_a(input logic c, input logic l, input logic [2:0] d,
                         input logic i, input logic dn, input logic m);
    ia.clr = c; ia.load = l; ia.d_in = d; ia.inc = i; ia.dec = dn; ia.mode = m;
    @(negedge clk);
  endtask

  task automatic drive_b(input logic c, input logic l, input logic [2:0] d,
                         input logic i, input logic dn, input logic m);
    ib.clr = c; ib.load = l; ib.d_in = d; ib.inc = i; ib.dec = dn; ib.mode = m;
    @(negedge clk);
  endtask

  task automatic drive_c(input logic c, input logic l, input logic [7:0] d,
                         input logic i, input logic dn, input logic m);
    ic.clr = c; ic.load = l; ic.d_in = d; ic.inc = i; ic.dec = dn; ic.mode = m;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    ia.clr = 0; ia.load = 0; ia.d_in = '0; ia.inc = 0; ia.dec = 0; ia.mode = 0;
    ib.clr = 0; ib.load = 0; ib.d_in = '0; ib.inc = 0; ib.dec = 0; ib.mode = 0;
    ic.clr = 0; ic.load = 0; ic.d_in = '0; ic.inc = 0; ic.dec = 0; ic.mode = 0;

    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk($sformatf("wrap_inc%0d", k), 0, 0, 3'd0, 1, 0, 0, k, 0, 0, 0));
    vecs.push_back(mk("wrap_7to0",    0, 0, 3'd0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("wrap_0to1",    0, 0, 3'd0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("load3",        0, 1, 3'd3, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk("inc_dec_hold", 0, 0, 3'd0, 1, 1, 0, 3, 0, 0, 0));
    vecs.push_back(mk("load_beats_inc", 0, 1, 3'd6, 1, 0, 0, 6, 0, 0, 0));
    vecs.push_back(mk("clr_beats_load", 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sat_dn_1",     0, 0, 3'd0, 0, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk("sat_dn_2",     0, 0, 3'd0, 0, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk("wrap_dn",      0, 0, 3'd0, 0, 1, 0, 7, 0, 1, 1));
    vecs.push_back(mk("idle",         0, 0, 3'd0, 0, 0, 0, 7, 0, 0, 1));
    vecs.push_back(mk("sat_up",       0, 0, 3'd0, 1, 0, 1, 7, 1, 0, 1));
    vecs.push_back(mk("wrap_up_ovf",  0, 0, 3'd0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("load_keeps_ovf", 0, 1, 3'd5, 0, 0, 0, 5, 0, 0, 1));
    vecs.push_back(mk("dec_mid",      0, 0, 3'd0, 0, 1, 0, 4, 0, 0, 1));
    vecs.push_back(mk("both_sat_mode", 0, 0, 3'd0, 1, 1, 1, 4, 0, 0, 1));
    vecs.push_back(mk("clr_ovf",      1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("inc_sat_mode_mid", 0, 0, 3'd0, 1, 0, 1, 1, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);
    reset_n = 1'b1;

    foreach (vecs[n]) begin
      drive_a(vecs[n].clr, vecs[n].load, vecs[n].d_in, vecs[n].inc, vecs[n].dec, vecs[n].mode);
      chk_a(vecs[n].name, vecs[n].e_count, vecs[n].e_up, vecs[n].e_dn, vecs[n].e_ovf);
    end
    drive_a(0, 0, 3'd0, 0, 0, 0);

    // MAX_VAL=5 saturate then wrap with sticky ovf
    drive_b(0, 1, 3'd4, 0, 0, 0); chk_b("b_load4", 4, 0, 0, 0);
    drive_b(0, 0, 3'd0, 1, 0, 1); chk_b("b_sat1", 5, 0, 0, 0);
    drive_b(0, 0, 3'd0, 1, 0, 1); chk_b("b_sat2", 5, 1, 0, 1);
    drive_b(0, 0, 3'd0, 1, 0, 1); chk_b("b_sat3", 5, 1, 0, 1);
    drive_b(0, 0, 3'd0, 1, 0, 0); chk_b("b_wrap", 0, 1, 0, 1);
    drive_b(0, 0, 3'd0, 1, 0, 0); chk_b("b_after_wrap", 1, 0, 0, 1);
    drive_b(1, 0, 3'd0, 0, 0, 0); chk_b("b_clr", 0, 0, 0, 0);
    drive_b(0, 1, 3'd7, 0, 0, 0); chk_b("b_load7_clamp", 5, 0, 0, 1);
    drive_b(1, 0, 3'd0, 0, 0, 0); chk_b("b_clr2", 0, 0, 0, 0);
    drive_b(0, 1, 3'd6, 0, 0, 0); chk_b("b_load6_clamp", 5, 0, 0, 1);
    drive_b(1, 0, 3'd0, 0, 0, 0); chk_b("b_clr3", 0, 0, 0, 0);
    drive_b(0, 1, 3'd5, 0, 0, 0); chk_b("b_load5_exact", 5, 0, 0, 0);
    drive_b(1, 0, 3'd0, 0, 0, 0); chk_b("b_clr4", 0, 0, 0, 0);
    drive_b(0, 0, 3'd0, 0, 1, 0); chk_b("b_wrap_dn", 5, 0, 1, 0);
    drive_b(0, 0, 3'd0, 0, 0, 0); chk_b("b_dn_pulse_end", 5, 0, 0, 0);

    // MAX_VAL=200 on an 8-bit counter: wrap must happen at 200, not 255
    drive_c(1, 0, 8'd0, 0, 0, 0);
    check("c_clr", int'(ic.count), 0);
    pulses = 0;
    for (int k = 1; k <= 201; k++) begin
      drive_c(0, 0, 8'd0, 1, 0, 0);
      if (ic.tc_up) pulses++;
      if (k == 200) check("c_at_200", int'(ic.count), 200);
    end
    check("c_wrapped", int'(ic.count), 0);
    check("c_tc_up_pulses", pulses, 1);
    drive_c(0, 0, 8'd0, 0, 1, 0);
    check("c_wrap_dn_count", int'(ic.count), 200);
    check("c_wrap_dn_pulse", int'(ic.tc_dn), 1);
    drive_c(0, 0, 8'd0, 0, 0, 0);

    // async reset between edges from count=6, ovf=1
    drive_a(1, 0, 3'd0, 0, 0, 0);
    drive_a(0, 0, 3'd0, 0, 1, 1);
    drive_a(0, 1, 3'd6, 0, 0, 0);
    chk_a("pre_reset", 6, 0, 0, 1);
    ia.load = 0;
    #2 reset_n = 1'b0;
    #1 chk_a("async_reset", 0, 0, 0, 0);
    ia.inc = 1;
    @(negedge clk);
    check("reset_holds_count", int'(ia.count), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_inc_after_reset", int'(ia.count), 1);
    ia.inc = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
